// File: rtl/tim_apb_master.sv
// Request/response to APB bridge for programming the timer registers.
// Runs one transfer at a time. ACCESS is aborted if tim_pready stays low for TIMEOUT_CYC cycles.
module tim_apb_master #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                tim_psel,
   output logic                tim_penable,
   output logic                tim_pwrite,
   output logic [ADDR_W-1:0]   tim_paddr,
   output logic [DATA_W-1:0]   tim_pwdata,
   output logic [DATA_W/8-1:0] tim_pstrb,
   input  logic [DATA_W-1:0]   tim_prdata,
   input  logic                tim_pready,
   input  logic                tim_pslverr
);

   localparam int STRB_W = DATA_W/8;
   localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC+1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC-1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_wait;
   logic                r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic [STRB_W-1:0]   r_pstrb;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;
   logic                r_tmo;
   logic                w_tmo_hit;

   // This ACCESS cycle is the TIMEOUT_CYC-th in a row with pready low.
   assign w_tmo_hit = (TIMEOUT_CYC != 0) && (r_wait == WAIT_LAST);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      tim_psel    = 1'b0;
      tim_penable = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = S_SETUP;
         end
         S_SETUP: begin
            tim_psel = 1'b1;
            w_next   = S_ACCESS;
         end
         S_ACCESS: begin
            tim_psel    = 1'b1;
            tim_penable = 1'b1;
            if (tim_pready || w_tmo_hit) w_next = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_wait   <= '0;
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pstrb  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         r_tmo    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_pwrite <= req_write;
                  r_paddr  <= req_addr;
                  r_pwdata <= req_wdata;
                  r_pstrb  <= req_write ? req_strb : '0;
               end
            end
            S_ACCESS: begin
               // A completion on the timeout cycle takes priority over the abort.
               if (tim_pready) begin
                  r_rdata <= r_pwrite ? '0 : tim_prdata;
                  r_err   <= tim_pslverr;
                  r_tmo   <= 1'b0;
               end else if (w_tmo_hit) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_tmo   <= 1'b1;
               end else if (r_wait != {CNT_W{1'b1}}) begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) r_wait <= '0;
            end
            default: ;
         endcase
      end
   end

   assign tim_pwrite  = r_pwrite;
   assign tim_paddr   = r_paddr;
   assign tim_pwdata  = r_pwdata;
   assign tim_pstrb   = tim_psel ? r_pstrb : '0;
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = r_err;
   assign rsp_timeout = r_tmo;

endmodule

// File: tb/tb_tim_apb_master.sv
// Directed bench for tim_apb_master: the bench drives the slave side of the APB bus directly.
module tb_tim_apb_master;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_strb;
   logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DATA_W-1:0] rsp_rdata;
   logic              tim_psel, tim_penable, tim_pwrite;
   logic [ADDR_W-1:0] tim_paddr;
   logic [DATA_W-1:0] tim_pwdata, tim_prdata;
   logic [3:0]        tim_pstrb;
   logic              tim_pready, tim_pslverr;

   int total = 0;
   int bad   = 0;

   tim_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
      .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
      .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
   endtask

   initial begin
      logic [31:0] hold;
      sys_rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
      req_strb = '0; rsp_ready = 0; tim_prdata = '0; tim_pready = 0; tim_pslverr = 0;
      repeat (3) step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_psel", tim_psel, 0);
      chk("rst_penable", tim_penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_pstrb", tim_pstrb, 0);
      sys_rst_n = 1'b1;
      step();

      // zero-wait write
      req(1, 12'h004, 32'h0000_00FF, 4'hF); tim_pready = 1;
      step();
      req_valid = 0;
      chk("wr_setup_psel", tim_psel, 1);
      chk("wr_setup_penable", tim_penable, 0);
      chk("wr_setup_req_ready", req_ready, 0);
      chk("wr_paddr", tim_paddr, 32'h004);
      chk("wr_pwdata", tim_pwdata, 32'hFF);
      chk("wr_pstrb", tim_pstrb, 4'hF);
      chk("wr_pwrite", tim_pwrite, 1);
      step();
      chk("wr_access_penable", tim_penable, 1);
      chk("wr_access_psel", tim_psel, 1);
      step();
      chk("wr_resp_valid", rsp_valid, 1);
      chk("wr_resp_psel", tim_psel, 0);
      chk("wr_resp_pstrb", tim_pstrb, 0);
      chk("wr_resp_err", rsp_err, 0);
      chk("wr_resp_rdata", rsp_rdata, 0);
      chk("wr_resp_req_ready", req_ready, 0);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("wr_done_rsp_valid", rsp_valid, 0);
      chk("wr_done_req_ready", req_ready, 1);

      // read with 2 wait states; prdata is garbage until pready
      req(0, 12'h008, 32'hFFFF_FFFF, 4'hF); tim_pready = 0; tim_prdata = 32'hDEAD_BEEF;
      step();
      req_valid = 0;
      chk("rd_setup_pstrb", tim_pstrb, 0);
      chk("rd_pwrite", tim_pwrite, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("rd_access_penable", tim_penable, 1);
         chk("rd_access_pstrb", tim_pstrb, 0);
         if (i == 2) begin tim_pready = 1; tim_prdata = 32'h1234_5678; end
         step();
      end
      chk("rd_resp_valid", rsp_valid, 1);
      chk("rd_resp_penable", tim_penable, 0);
      chk("rd_resp_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd_resp_err", rsp_err, 0);
      rsp_ready = 1; step(); rsp_ready = 0;

      // write with slave error, then a normal read
      req(1, 12'h00C, 32'hCAFE_0001, 4'h3); tim_pready = 1; tim_pslverr = 1;
      step(); req_valid = 0;
      chk("err_pstrb", tim_pstrb, 4'h3);
      step(); step();
      chk("err_resp_valid", rsp_valid, 1);
      chk("err_rsp_err", rsp_err, 1);
      chk("err_rsp_timeout", rsp_timeout, 0);
      chk("err_rsp_rdata", rsp_rdata, 0);
      rsp_ready = 1; step(); rsp_ready = 0; tim_pslverr = 0;
      req(0, 12'h010, 32'h0, 4'hF); tim_prdata = 32'h0000_A5A5;
      step(); req_valid = 0;
      chk("after_err_psel", tim_psel, 1);
      chk("after_err_paddr", tim_paddr, 32'h010);
      step(); step();
      chk("after_err_rdata", rsp_rdata, 32'h0000_A5A5);
      chk("after_err_rsp_err", rsp_err, 0);
      rsp_ready = 1; step(); rsp_ready = 0;

      // timeout: pready low for 16 ACCESS cycles
      req(0, 12'h014, 32'h0, 4'hF); tim_pready = 0; tim_prdata = 32'h7777_7777;
      step(); req_valid = 0;
      step();
      for (int k = 1; k <= 16; k++) begin
         chk("tmo_access_psel", tim_psel, 1);
         chk("tmo_access_penable", tim_penable, 1);
         step();
      end
      chk("tmo_psel_dropped", tim_psel, 0);
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_rsp_err", rsp_err, 1);
      chk("tmo_rsp_timeout", rsp_timeout, 1);
      chk("tmo_rsp_rdata", rsp_rdata, 0);
      rsp_ready = 1; step(); rsp_ready = 0;

      // boundary: pready rises on exactly the 16th ACCESS cycle
      req(0, 12'h018, 32'h0, 4'hF);
      step(); req_valid = 0;
      step();
      for (int k = 1; k <= 16; k++) begin
         chk("bnd_access_penable", tim_penable, 1);
         if (k == 16) begin tim_pready = 1; tim_prdata = 32'h0BAD_F00D; end
         step();
      end
      chk("bnd_rsp_valid", rsp_valid, 1);
      chk("bnd_rsp_timeout", rsp_timeout, 0);
      chk("bnd_rsp_err", rsp_err, 0);
      chk("bnd_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
      rsp_ready = 1; step(); rsp_ready = 0;

      // response backpressure with a second request waiting
      req(0, 12'h01C, 32'h0, 4'hF); tim_pready = 1; tim_prdata = 32'h5A5A_0011;
      step(); step(); step();
      hold = 32'h5A5A_0011;
      req(1, 12'h020, 32'h1111_2222, 4'hF); tim_prdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, hold);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_psel", tim_psel, 0);
         step();
      end
      rsp_ready = 1; step(); rsp_ready = 0;
      chk("bp_hs_req_ready", req_ready, 1);
      chk("bp_hs_rsp_valid", rsp_valid, 0);
      step(); req_valid = 0;
      chk("bp_second_psel", tim_psel, 1);
      chk("bp_second_paddr", tim_paddr, 32'h020);
      step(); step();
      chk("bp_second_rsp_valid", rsp_valid, 1);
      chk("bp_second_rdata", rsp_rdata, 0);
      rsp_ready = 1; step(); rsp_ready = 0;

      // reset during ACCESS, then a clean read
      req(0, 12'h024, 32'h0, 4'hF); tim_pready = 0;
      step(); req_valid = 0;
      step();
      chk("mid_rst_in_access", tim_penable, 1);
      sys_rst_n = 0;
      step();
      chk("mid_rst_psel", tim_psel, 0);
      chk("mid_rst_penable", tim_penable, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      sys_rst_n = 1;
      req(0, 12'h028, 32'h0, 4'hF); tim_pready = 1; tim_prdata = 32'h0000_55AA;
      step(); req_valid = 0;
      chk("post_rst_psel", tim_psel, 1);
      step(); step();
      chk("post_rst_rsp_valid", rsp_valid, 1);
      chk("post_rst_rdata", rsp_rdata, 32'h0000_55AA);
      chk("post_rst_err", rsp_err, 0);
      rsp_ready = 1; step(); rsp_ready = 0;
      chk("post_rst_req_ready", req_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
